// File: rtl/mmu_sram_arbiter.sv
// mmu_sram_arbiter: shares one synchronous SRAM port between a CPU requester
// (port 0) and a blitter requester (port 1). The grant is combinational
// round-robin with a bounded hold. Read data comes back one cycle after the
// grant and is then held per port until that port's next read return.
module mmu_sram_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             rd_en_i,
  input  logic [1:0]             wt_en_i,
  input  logic [1:0][ADDR_W-1:0] rd_addr_i,
  input  logic [1:0][ADDR_W-1:0] wt_addr_i,
  input  logic [1:0][DATA_W-1:0] wt_data_i,
  output logic [1:0]             ready_o,
  output logic [1:0]             valid_o,
  output logic [1:0][DATA_W-1:0] rd_data_o,
  output logic                   sram_wt_en,
  output logic [ADDR_W-1:0]      sram_wt_addr,
  output logic [DATA_W-1:0]      sram_wt_data,
  output logic [ADDR_W-1:0]      sram_rd_addr,
  input  logic [DATA_W-1:0]      sram_rd_data
);

  localparam int             HW         = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  MAX_HOLD_C = HW'(MAX_HOLD);

  logic [1:0]             req_s;
  logic                   gnt_vld_s;
  logic                   gnt_port_s;
  logic                   rd_accept_s;
  logic                   last_grant_q;
  logic [HW-1:0]          hold_cnt_q;
  logic [HW-1:0]          hold_cnt_d;
  logic [1:0]             valid_q;
  logic [1:0][DATA_W-1:0] data_q;

  // Pick at most one port per cycle. A tie stays with the previous winner
  // only while a run is in progress and below the hold limit; a fresh tie
  // (after idle or reset) goes to the port that did not win last, which is
  // why last_grant resets to 1 so that the CPU wins the first tie.
  always_comb begin
    req_s      = rd_en_i | wt_en_i;
    gnt_vld_s  = 1'b0;
    gnt_port_s = 1'b0;
    case (req_s)
      2'b01: begin
        gnt_vld_s  = 1'b1;
        gnt_port_s = 1'b0;
      end
      2'b10: begin
        gnt_vld_s  = 1'b1;
        gnt_port_s = 1'b1;
      end
      2'b11: begin
        gnt_vld_s = 1'b1;
        if ((hold_cnt_q != '0) && (hold_cnt_q < MAX_HOLD_C)) begin
          gnt_port_s = last_grant_q;
        end else begin
          gnt_port_s = ~last_grant_q;
        end
      end
      default: begin
        gnt_vld_s  = 1'b0;
        gnt_port_s = 1'b0;
      end
    endcase
    // Keep the SRAM and handshake quiet while reset is held.
    if (rst) begin
      gnt_vld_s = 1'b0;
    end else begin
      gnt_vld_s = gnt_vld_s;
    end
  end

  // Route the winner onto the SRAM port and acknowledge it in the same cycle.
  always_comb begin
    ready_o      = 2'b00;
    sram_wt_en   = 1'b0;
    sram_wt_addr = '0;
    sram_wt_data = '0;
    sram_rd_addr = '0;
    rd_accept_s  = 1'b0;
    if (gnt_vld_s) begin
      ready_o[gnt_port_s] = 1'b1;
      sram_wt_en          = wt_en_i[gnt_port_s];
      sram_wt_addr        = wt_addr_i[gnt_port_s];
      sram_wt_data        = wt_data_i[gnt_port_s];
      sram_rd_addr        = rd_addr_i[gnt_port_s];
      // A port asserting read and write together gets the write only.
      rd_accept_s         = rd_en_i[gnt_port_s] & ~wt_en_i[gnt_port_s];
    end else begin
      rd_accept_s = 1'b0;
    end
  end

  // Length of the current run of grants to the same port, saturating at the limit.
  always_comb begin
    hold_cnt_d = '0;
    if (gnt_vld_s) begin
      if ((hold_cnt_q != '0) && (gnt_port_s == last_grant_q)) begin
        if (hold_cnt_q == MAX_HOLD_C) begin
          hold_cnt_d = hold_cnt_q;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end else begin
        hold_cnt_d = HW'(1);
      end
    end else begin
      hold_cnt_d = '0;
    end
  end

  // Arbitration history, pending-read tracking and per-port held read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      hold_cnt_q   <= '0;
      valid_q      <= 2'b00;
      data_q       <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      if (gnt_vld_s) begin
        last_grant_q <= gnt_port_s;
      end
      valid_q <= 2'b00;
      if (rd_accept_s) begin
        valid_q[gnt_port_s] <= 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        if (valid_q[p]) begin
          data_q[p] <= sram_rd_data;
        end
      end
    end
  end

  // The returning port sees SRAM data directly in its valid cycle, then the held copy.
  always_comb begin
    valid_o = valid_q;
    for (int p = 0; p < 2; p++) begin
      if (valid_q[p]) begin
        rd_data_o[p] = sram_rd_data;
      end else begin
        rd_data_o[p] = data_q[p];
      end
    end
  end

endmodule
